divide_iter: RTL and testbench

- Parametrised successor to divide_top: signed fixed-point divider computing (dividend << Q_BITS) / divisor.
- Iterative radix-2 restoring datapath, one quotient bit per cycle.
- Sits between two first-word-fall-through input FIFOs (dividend, divisor) and one output FIFO.
- Adds selectable rounding, saturation on overflow, divide-by-zero handling and a per-result status word.

---
 rtl/divide_iter.sv | 110 +++++++++++
 tb/tb_divide_iter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/divide_iter.sv
// divide_iter: signed fixed-point divider, (dividend << Q_BITS) / divisor,
// computed by a radix-2 restoring loop between FWFT input FIFOs and an output FIFO.
// Ports: clock, reset (async, active low); dividend/divisor/in_empty/in_rd_en
// form the input FIFO side; out_full/out_wr_en/out_dout/out_status form the
// output FIFO side (status bit0 = divide by zero, bit1 = saturated).
module divide_iter #(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10,
    parameter int ROUND   = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    input  logic               in_empty,
    output logic               in_rd_en,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic [D_WIDTH-1:0] out_dout,
    output logic [1:0]         out_status
);
    localparam int N  = D_WIDTH + Q_BITS;
    localparam int CW = $clog2(N);
    localparam logic [N:0] MAX_MAG = {{(N-D_WIDTH+2){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic [N:0] MIN_MAG = MAX_MAG + 1'b1;
    localparam logic [D_WIDTH-1:0] MAX_D = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] MIN_D = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, WRITE} state_t;
    state_t state;

    logic [N:0]         num;
    logic [D_WIDTH:0]   den;
    logic [D_WIDTH:0]   rem;
    logic [N-1:0]       quo;
    logic [CW-1:0]      count;
    logic               sign, dsign, div0;

    logic [D_WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
    logic [D_WIDTH+1:0] trial, diff;
    logic               ge, up, ovf;
    logic [N:0]         mag;
    logic [D_WIDTH-1:0] res, fix_dout;
    logic [1:0]         fix_status;

    // One extra bit keeps |-2^(D_WIDTH-1)| exact.
    assign a_ext = {dividend[D_WIDTH-1], dividend};
    assign b_ext = {divisor[D_WIDTH-1], divisor};
    assign a_mag = dividend[D_WIDTH-1] ? -a_ext : a_ext;
    assign b_mag = divisor[D_WIDTH-1] ? -b_ext : b_ext;

    // The borrow out of the trial subtraction decides the quotient bit.
    assign trial = {rem, num[N-1]};
    assign diff  = trial - {1'b0, den};
    assign ge    = ~diff[D_WIDTH+1];

    assign up  = (ROUND != 0) && ({rem, 1'b0} >= {1'b0, den});
    assign mag = {1'b0, quo} + {{N{1'b0}}, up};
    assign ovf = sign ? (mag > MIN_MAG) : (mag > MAX_MAG);
    assign res = sign ? -mag[D_WIDTH-1:0] : mag[D_WIDTH-1:0];
    assign fix_dout   = div0 ? (dsign ? MIN_D : MAX_D) : ovf ? (sign ? MIN_D : MAX_D) : res;
    assign fix_status = div0 ? 2'b01 : {ovf, 1'b0};

    assign in_rd_en  = (state == IDLE) && !in_empty;
    assign out_wr_en = (state == WRITE) && !out_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            num        <= '0;
            den        <= '0;
            rem        <= '0;
            quo        <= '0;
            count      <= '0;
            sign       <= 1'b0;
            dsign      <= 1'b0;
            div0       <= 1'b0;
            out_dout   <= '0;
            out_status <= '0;
        end else begin
            case (state)
                IDLE: if (!in_empty) begin
                    num   <= {a_mag, {Q_BITS{1'b0}}};
                    den   <= b_mag;
                    rem   <= '0;
                    quo   <= '0;
                    sign  <= dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
                    dsign <= dividend[D_WIDTH-1];
                    div0  <= (divisor == '0);
                    count <= CW'(N-1);
                    state <= ITER;
                end
                ITER: begin
                    num   <= num << 1;
                    rem   <= ge ? diff[D_WIDTH:0] : trial[D_WIDTH:0];
                    quo   <= {quo[N-2:0], ge};
                    count <= count - 1'b1;
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    out_dout   <= fix_dout;
                    out_status <= fix_status;
                    state      <= WRITE;
                end
                WRITE: if (!out_full) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divide_iter.sv
// tb_divide_iter: directed and backpressure checks of divide_iter in both rounding modes.
module tb_divide_iter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        in_empty = 1'b1, out_full = 1'b0;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] q0, q1;
    logic [1:0]  s0, s1;
    int          total = 0, bad = 0;
    logic [31:0] ra [16];
    logic [31:0] rb [16];
    logic [33:0] m0, m1;

    always #5 clock = ~clock;

    divide_iter #(.D_WIDTH(32), .Q_BITS(10), .ROUND(0)) dut0 (
        .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
        .in_empty(in_empty), .in_rd_en(rd0), .out_full(out_full),
        .out_wr_en(wr0), .out_dout(q0), .out_status(s0));

    divide_iter #(.D_WIDTH(32), .Q_BITS(10), .ROUND(1)) dut1 (
        .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
        .in_empty(in_empty), .in_rd_en(rd1), .out_full(out_full),
        .out_wr_en(wr1), .out_dout(q1), .out_status(s1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Golden model: {status, quotient} via integer division on magnitudes.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input bit rnd);
        longint am, bm, qm, rm;
        bit neg;
        if (b == 0) return {2'b01, a[31] ? 32'h80000000 : 32'h7fffffff};
        am = a[31] ? -longint'($signed(a)) : longint'($signed(a));
        bm = b[31] ? -longint'($signed(b)) : longint'($signed(b));
        am = am <<< 10;
        qm = am / bm;
        rm = am % bm;
        if (rnd && 2 * rm >= bm) qm++;
        neg = a[31] ^ b[31];
        if (!neg && qm > 64'h7fffffff) return {2'b10, 32'h7fffffff};
        if (neg && qm > 64'h80000000) return {2'b10, 32'h80000000};
        return {2'b00, neg ? 32'(-qm) : 32'(qm)};
    endfunction

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] es);
        int lat;
        @(negedge clock);
        dividend = a; divisor = b; in_empty = 1'b0;
        #1;
        chk({tag, " rd_en"}, 64'(rd0), 64'(1));
        @(posedge clock);
        #1 in_empty = 1'b1;
        @(negedge clock);
        lat = 1;
        while (!wr0 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(44));
        chk({tag, " dout"}, 64'(q0), 64'(e0));
        chk({tag, " status"}, 64'(s0), 64'(es));
        chk({tag, " wr_round"}, 64'(wr1), 64'(1));
        chk({tag, " dout_round"}, 64'(q1), 64'(e1));
        chk({tag, " status_round"}, 64'(s1), 64'(es));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset dout", 64'(q0), 64'(0));
        chk("reset status", 64'(s0), 64'(0));
        chk("reset rd_en", 64'(rd0), 64'(0));
        chk("reset wr_en", 64'(wr0), 64'(0));
        reset = 1'b1;

        run("3/2",      32'h00000C00, 32'h00000800, 32'h00000600, 32'h00000600, 2'b00);
        run("-3/2",     32'hFFFFF400, 32'h00000800, 32'hFFFFFA00, 32'hFFFFFA00, 2'b00);
        run("2/3",      32'h00000800, 32'h00000C00, 32'h000002AA, 32'h000002AB, 2'b00);
        run("1/3",      32'h00000400, 32'h00000C00, 32'h00000155, 32'h00000155, 2'b00);
        run("0/-1",     32'h00000000, 32'hFFFFFC00, 32'h00000000, 32'h00000000, 2'b00);
        run("div0 pos", 32'h00000400, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b01);
        run("div0 neg", 32'hFFFFFC00, 32'h00000000, 32'h80000000, 32'h80000000, 2'b01);
        run("ovf max",  32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b10);
        run("min/-1",   32'h80000000, 32'hFFFFFC00, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'b10);
        run("min/1",    32'h80000000, 32'h00000400, 32'h80000000, 32'h80000000, 2'b00);

        for (int i = 0; i < 16; i++) begin
            ra[i] = $urandom >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) ra[i] = -ra[i];
            rb[i] = $urandom >> $urandom_range(4, 28);
            if ($urandom_range(0, 1) == 1) rb[i] = -rb[i];
        end
        for (int i = 0; i < 16; i++) begin
            m0 = model(ra[i], rb[i], 1'b0);
            m1 = model(ra[i], rb[i], 1'b1);
            @(negedge clock);
            dividend = ra[i]; divisor = rb[i]; in_empty = 1'b0; out_full = 1'b1;
            #1;
            chk("bp rd_en", 64'(rd0), 64'(1));
            @(posedge clock);
            #1 dividend = ~ra[i];
            for (int c = 1; c <= 48; c++) begin
                @(negedge clock);
                chk("bp rd_idle", 64'(rd0), 64'(0));
                chk("bp wr_hold", 64'(wr0), 64'(0));
                if (c >= 44) begin
                    chk("bp dout_hold", 64'(q0), 64'(m0[31:0]));
                    chk("bp status_hold", 64'(s0), 64'(m0[33:32]));
                end
            end
            @(negedge clock);
            out_full = 1'b0;
            #1;
            chk("bp wr", 64'(wr0), 64'(1));
            chk("bp dout", 64'(q0), 64'(m0[31:0]));
            chk("bp status", 64'(s0), 64'(m0[33:32]));
            chk("bp dout_round", 64'(q1), 64'(m1[31:0]));
            chk("bp status_round", 64'(s1), 64'(m1[33:32]));
        end

        run("pre-reset", 32'h00000C00, 32'h00000800, 32'h00000600, 32'h00000600, 2'b00);
        @(negedge clock);
        dividend = 32'h00000800; divisor = 32'h00000C00; in_empty = 1'b0;
        @(posedge clock);
        #1 in_empty = 1'b1;
        repeat (20) @(negedge clock);
        chk("mid dout", 64'(q0), 64'h600);
        reset = 1'b0;
        #1;
        chk("rst dout", 64'(q0), 64'(0));
        chk("rst status", 64'(s0), 64'(0));
        chk("rst wr_en", 64'(wr0), 64'(0));
        chk("rst rd_en", 64'(rd0), 64'(0));
        chk("rst dout_round", 64'(q1), 64'(0));
        repeat (3) begin
            @(negedge clock);
            chk("rst no write", 64'(wr0), 64'(0));
        end
        reset = 1'b1;
        run("post-reset", 32'h00000400, 32'h00000C00, 32'h00000155, 32'h00000155, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
